// File: rtl/button_event_decoder_pkg.sv
// Shared constants for the pushbutton event decoder: FSM state encoding and default timing.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int unsigned LONG_MS_DEF   = 1000;
  localparam int unsigned REPEAT_MS_DEF = 200;
  localparam int unsigned CNT_W_DEF     = 11;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level/tick inputs and the decoded event outputs bundled for the decoder.
interface button_event_decoder_if #(
  parameter int unsigned CNT_W = 11
);

  logic             Clk1KHzEn;
  logic             sig_clean;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic             held;
  logic [CNT_W-1:0] hold_ms;

  modport master (
    output Clk1KHzEn, sig_clean,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, hold_ms
  );

  modport slave (
    input  Clk1KHzEn, sig_clean,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, hold_ms
  );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// Registered-history edge detector for a clean button level; rise/fall are combinational.
module edge_detect (
  input  logic Clk100MHz,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // Reset loads the live level so a button held through reset never looks like a fresh press.
  always_ff @(posedge Clk100MHz) begin
    if (reset) sig_d <= sig;
    else       sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat pulses timed by the 1 kHz tick.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                   Clk100MHz,
  input  logic                   reset,
  button_event_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  state_t           state;
  logic [CNT_W-1:0] ms_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             rise;
  logic             fall;

  edge_detect u_edge (
    .Clk100MHz (Clk100MHz),
    .reset     (reset),
    .sig       (bus.sig_clean),
    .rise      (rise),
    .fall      (fall)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A fall always beats a coincident tick, so release never carries a long/repeat pulse.
  always_ff @(posedge Clk100MHz) begin
    if (reset) begin
      state             <= ST_IDLE;
      ms_cnt            <= '0;
      rep_cnt           <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
      bus.hold_ms       <= '0;
    end else begin
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state           <= ST_PRESS;
            bus.press_pulse <= 1'b1;
            bus.held        <= 1'b1;
            ms_cnt          <= '0;
            bus.hold_ms     <= '0;
          end
        end
        ST_PRESS: begin
          if (fall) begin
            state             <= ST_IDLE;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else if (bus.Clk1KHzEn) begin
            ms_cnt      <= ms_cnt + CNT_W'(1);
            bus.hold_ms <= sat_inc(bus.hold_ms);
            if (ms_cnt == LONG_LAST) begin
              state          <= ST_HOLD;
              bus.long_pulse <= 1'b1;
              rep_cnt        <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state             <= ST_IDLE;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else if (bus.Clk1KHzEn) begin
            bus.hold_ms <= sat_inc(bus.hold_ms);
            if (REPEAT_MS != 0) begin
              if (rep_cnt == REP_LAST) begin
                bus.repeat_pulse <= 1'b1;
                rep_cnt          <= '0;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule
